// File: rtl/wb_pkg.sv
// Shared constants for the two-port register-file writeback arbiter.
package wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W_DEF = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a combinational one-hot grant.
module rr_arbiter2
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_i,
  input  logic       req1_i,
  output logic [1:0] grant_o
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_o  = 2'b00;
    rr_ptr_d = rr_ptr_q;
    if (req0_i && req1_i) begin
      // Conflict: the pointer names the winner, then moves to the loser.
      grant_o[rr_ptr_q] = 1'b1;
      rr_ptr_d          = ~rr_ptr_q;
    end else begin
      grant_o[REQ_ALU] = req0_i;
      grant_o[REQ_MEM] = req1_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments and clears on the asynchronous reset edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= 1'(REQ_ALU);
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates ALU and load/multiply writebacks onto a single register-file write port.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [REG_ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0]     req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [REG_ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0]     req1_data,
  output logic                  req1_ready,
  output logic                  rf_reg_write,
  output logic [REG_ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0]     rf_write_data,
  output logic                  busy_valid,
  output logic [REG_ADDR_W-1:0] busy_reg,
  output logic [CNT_W-1:0]      grant_cnt0,
  output logic [CNT_W-1:0]      grant_cnt1
);

  logic [1:0]            grant;
  logic                  rf_we_q,   rf_we_d;
  logic [REG_ADDR_W-1:0] rf_reg_q,  rf_reg_d;
  logic [DATA_W-1:0]     rf_data_q, rf_data_d;
  logic [CNT_W-1:0]      cnt0_q,    cnt0_d;
  logic [CNT_W-1:0]      cnt1_q,    cnt1_d;

  // Requests are masked while reset is held so no transfer can be granted.
  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req0_i  (req0_valid & ~rst),
    .req1_i  (req1_valid & ~rst),
    .grant_o (grant)
  );

  assign req0_ready = grant[REQ_ALU];
  assign req1_ready = grant[REQ_MEM];

  always_comb begin
    rf_we_d   = 1'b0;
    rf_reg_d  = rf_reg_q;
    rf_data_d = rf_data_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    // Writes to r0 are accepted and counted but never enable the port.
    if (grant[REQ_MEM]) begin
      rf_reg_d  = req1_reg;
      rf_data_d = req1_data;
      rf_we_d   = (req1_reg != REG_ZERO);
      if (cnt1_q != '1) cnt1_d = cnt1_q + 1'b1;
    end else if (grant[REQ_ALU]) begin
      rf_reg_d  = req0_reg;
      rf_data_d = req0_data;
      rf_we_d   = (req0_reg != REG_ZERO);
      if (cnt0_q != '1) cnt0_d = cnt0_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q   <= 1'b0;
      rf_reg_q  <= '0;
      rf_data_q <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_reg_q  <= rf_reg_d;
      rf_data_q <= rf_data_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  assign rf_reg_write  = rf_we_q;
  assign rf_write_reg  = rf_reg_q;
  assign rf_write_data = rf_data_q;
  assign busy_valid    = rf_we_q;
  assign busy_reg      = rf_reg_q;
  assign grant_cnt0    = cnt0_q;
  assign grant_cnt1    = cnt1_q;

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: write-data width.
REQ-002 Parameter CNT_W, default 16: width of each per-requester grant counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-006 req0_reg  input  5  requester 0 destination register number.
REQ-007 req0_data  input  DATA_W  requester 0 write data.
REQ-008 req0_ready  output  1  requester 0 write accepted this cycle.
REQ-009 req1_valid / req1_reg / req1_data / req1_ready: same as REQ-005..008 for requester 1 (load/multiply unit).
REQ-010 rf_reg_write  output  1  write enable to the register file.
REQ-011 rf_write_reg  output  5  register-file write address.
REQ-012 rf_write_data  output  DATA_W  register-file write data.
REQ-013 busy_valid / busy_reg  output  1 / 5  in-flight write visible for hazard checks; equals rf_reg_write / rf_write_reg.
REQ-014 grant_cnt0, grant_cnt1  output  CNT_W  saturating count of grants per requester.

Function
REQ-015 A transfer on requester N occurs when reqN_valid and reqN_ready are both 1 in the same cycle.
REQ-016 reqN_ready shall be combinational and shall never be 1 for both requesters in the same cycle.
REQ-017 Only one requester valid: that requester shall be granted (ready = 1) in the same cycle.
REQ-018 Both requesters valid: grant the requester indicated by the round-robin pointer rr_ptr (0 or 1).
REQ-019 rr_ptr shall update only on a two-way conflict cycle, and then to the requester that lost; single-requester grants shall leave it unchanged.
REQ-020 Neither requester valid: both readys shall be 0, and rr_ptr and the counters shall hold.
REQ-021 The granted reg and data shall be registered into rf_write_reg and rf_write_data, with rf_reg_write = 1, on the next posedge (latency 1 cycle).
REQ-022 A cycle with no grant shall drive rf_reg_write = 0 on the next cycle; rf_write_reg and rf_write_data shall hold their previous values.
REQ-023 A granted write to register 0 shall be accepted (ready = 1) and counted, but shall drive rf_reg_write = 0.
REQ-024 The output stage shall never stall: back-to-back grants shall produce back-to-back writes.
REQ-025 grant_cntN shall increment by 1 on each requester N transfer and shall saturate at all-ones with no wrap.
REQ-026 A requester that keeps valid asserted under continuous contention shall wait at most 1 cycle between grants.

Reset
REQ-027 Asserting rst shall immediately force rf_reg_write = 0, rf_write_reg = 0, rf_write_data = 0, rr_ptr = 0, and grant_cnt0 = grant_cnt1 = 0.
REQ-028 While rst = 1, req0_ready and req1_ready shall be 0, and no transfer shall occur.
REQ-029 A write that is in flight when rst asserts shall be dropped and never reach the register file.
REQ-030 The first grant after rst deasserts shall be on the first clock edge at which any valid is 1; under contention, requester 0 shall be granted first.

Structure
REQ-031 Package wb_pkg shall hold REG_ADDR_W = 5, DATA_W_DEF = 32, REG_ZERO = 5'd0 and the requester index constants REQ_ALU = 0 and REQ_MEM = 1.
REQ-032 Grant logic and rr_ptr shall reside in sub-module rr_arbiter2 (inputs: two requests; outputs: one-hot grant); counters and the output register shall reside in the top module.

Verification
REQ-033 Scenario: reset, then req0 writes reg 5 = 0x12345678 alone -> req0_ready = 1 the same cycle; next cycle rf_reg_write = 1, rf_write_reg = 5, rf_write_data = 0x12345678; grant_cnt0 = 1.
REQ-034 Scenario: both valid for 4 cycles (reg 1/0xA, reg 2/0xB) -> grant order 0,1,0,1; rf_write_reg sequence 1,2,1,2; grant_cnt0 = grant_cnt1 = 2.
REQ-035 Scenario: req1 writes reg 0, data 0xFFFFFFFF -> req1_ready = 1, grant_cnt1 increments, and rf_reg_write stays 0 on the following cycle.
REQ-036 Scenario: rst asserted mid-cycle while rf_reg_write = 1 -> rf_reg_write = 0 immediately without a clock edge, and counters = 0.
REQ-037 Scenario: CNT_W = 4 and req0 continuously valid for 20 cycles -> grant_cnt0 saturates at 15.
REQ-038 Scenario: req0 only, then req1 only, then both -> rr_ptr is unchanged by the single grants, and req0 wins the first conflict.
